// File: rtl/cache_dados_pkg.sv
// Shared definitions for the data cache and its memory-side refill engine:
// line geometry, refill FSM state encoding and address field extractors.
package cache_dados_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned WORDS      = 4;
    localparam int unsigned INDEX_W    = 5;
    localparam int unsigned OFFSET_W   = 4;
    localparam int unsigned TAG_W      = 23;
    localparam int unsigned WSEL_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_FILL  = 2'd3
    } state_e;

    // Tag field of a byte address.
    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    // Line index field of a byte address.
    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    // Word-within-line select of a byte address.
    function automatic logic [WSEL_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
        return a[2 +: WSEL_W];
    endfunction

endpackage

// File: rtl/cache_dados_refill_store_buffer_1e.sv
// Single-entry store buffer holding one write-through (address + data).
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   accept            load addr_in/data_in; ignored while full
//   drain             entry written to memory, release it
//   addr_in, data_in  store being offered
//   full              entry valid
//   addr, data        buffered store
module store_buffer_1e #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              accept,
    input  logic              drain,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // Accept and drain are mutually exclusive: accept needs empty, drain needs full.
    always_ff @(posedge clock) begin
        if (reset) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (accept && !full) begin
            full <= 1'b1;
            addr <= addr_in;
            data <= data_in;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/cache_dados_refill.sv
// Memory-side refill engine for the direct-mapped data cache.
// Fetches a 16-byte line as four 32-bit read beats on a miss and hands it
// back as a one-cycle fill; drains store write-throughs from a one-entry buffer.
// Ports:
//   clock, reset                    rising-edge clock, synchronous active-high reset
//   miss_req, miss_addr             read miss (level, held until fill)
//   wr_req, wr_addr, wr_data        store write-through (pulse); wr_busy = buffer full
//   mem_req/we/addr/wdata           memory beat request
//   mem_ack, mem_rdata              beat completion and read data
//   fill_valid/index/tag/data       line fill toward the cache
module cache_dados_refill #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INDEX_W = 5,
    parameter int unsigned WORDS   = 4
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      miss_req,
    input  logic [ADDR_W-1:0]                         miss_addr,
    input  logic                                      wr_req,
    input  logic [ADDR_W-1:0]                         wr_addr,
    input  logic [31:0]                               wr_data,
    output logic                                      wr_busy,
    output logic                                      mem_req,
    output logic                                      mem_we,
    output logic [ADDR_W-1:0]                         mem_addr,
    output logic [31:0]                               mem_wdata,
    input  logic                                      mem_ack,
    input  logic [31:0]                               mem_rdata,
    output logic                                      fill_valid,
    output logic [INDEX_W-1:0]                        fill_index,
    output logic [ADDR_W-INDEX_W-$clog2(WORDS)-3:0]   fill_tag,
    output logic [32*WORDS-1:0]                       fill_data
);

    import cache_dados_pkg::*;

    localparam int unsigned CNT_W  = $clog2(WORDS);
    localparam int unsigned OFF_W  = CNT_W + 2;
    localparam int unsigned BASE_W = ADDR_W - OFF_W;
    localparam int unsigned TAG_B  = BASE_W - INDEX_W;
    localparam int unsigned LINE_W = 32 * WORDS;

    state_e              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [BASE_W-1:0]   base, base_d;
    logic [LINE_W-1:0]   line_q;

    logic                word_we_c;
    logic                wbuf_drain_c;
    logic                wr_accept_c;
    logic                wbuf_full;
    logic [ADDR_W-1:0]   wbuf_addr;
    logic [31:0]         wbuf_data;

    logic                mem_req_d, mem_we_d, fill_valid_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [31:0]         mem_wdata_d;

    // Byte offset within the line is implied by the beat counter.
    logic                unused_offset_c;
    assign unused_offset_c = ^miss_addr[OFF_W-1:0];

    assign wr_accept_c = wr_req && !wbuf_full;

    store_buffer_1e #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_wbuf (
        .clock   (clock),
        .reset   (reset),
        .accept  (wr_req),
        .drain   (wbuf_drain_c),
        .addr_in (wr_addr),
        .data_in (wr_data),
        .full    (wbuf_full),
        .addr    (wbuf_addr),
        .data    (wbuf_data)
    );

    // Next state, beat counter, line base and next registered outputs.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        base_d       = base;
        word_we_c    = 1'b0;
        wbuf_drain_c = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // A store entering the buffer this cycle blocks the miss so it
                // reaches memory before the load (RAW through memory).
                if (wbuf_full) begin
                    state_d = ST_WRITE;
                end else if (miss_req && !wr_accept_c) begin
                    base_d  = miss_addr[ADDR_W-1:OFF_W];
                    cnt_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    wbuf_drain_c = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_READ: begin
                if (mem_ack) begin
                    word_we_c = 1'b1;
                    cnt_d     = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WORDS - 1)) begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_req_d    = (state_d == ST_READ) || (state_d == ST_WRITE);
        mem_we_d     = (state_d == ST_WRITE);
        fill_valid_d = (state_d == ST_FILL);
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        if (state_d == ST_WRITE) begin
            mem_addr_d  = wbuf_addr;
            mem_wdata_d = wbuf_data;
        end else if (state_d == ST_READ) begin
            mem_addr_d = {base_d, cnt_d, 2'b00};
        end
    end

    // State, counter, line buffer and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            base       <= '0;
            line_q     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            fill_valid <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            base       <= base_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            fill_valid <= fill_valid_d;
            for (int k = 0; k < int'(WORDS); k++) begin
                if (word_we_c && (cnt == CNT_W'(k))) begin
                    line_q[32*k +: 32] <= mem_rdata;
                end
            end
        end
    end

    assign wr_busy    = wbuf_full;
    assign fill_data  = line_q;
    assign fill_index = base[INDEX_W-1:0];
    assign fill_tag   = base[BASE_W-1 -: TAG_B];

endmodule

// File: tb/tb_cache_dados_refill.sv
// Directed bench for cache_dados_refill: refill timing, stalled beats,
// store priority, buffer-full behaviour, store during refill, reset abort.
module tb_cache_dados_refill;

    logic          clock;
    logic          reset;
    logic          miss_req;
    logic [31:0]   miss_addr;
    logic          wr_req;
    logic [31:0]   wr_addr;
    logic [31:0]   wr_data;
    logic          wr_busy;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          fill_valid;
    logic [4:0]    fill_index;
    logic [22:0]   fill_tag;
    logic [127:0]  fill_data;

    int vectors     = 0;
    int miscompares = 0;

    cache_dados_refill dut (
        .clock      (clock),
        .reset      (reset),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_busy    (wr_busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .fill_valid (fill_valid),
        .fill_index (fill_index),
        .fill_tag   (fill_tag),
        .fill_data  (fill_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called in the first READ cycle. Each beat waits 'waits' cycles before ack;
    // optionally offers a store on the ack cycle of beat 'wr_beat'.
    // Returns in the cycle after the fill, with miss_req dropped.
    task automatic run_beats(input logic [31:0] base, input logic [31:0] rd0, input int waits,
                             input int wr_beat, input logic [31:0] wa, input logic [31:0] wd,
                             input logic [4:0] exp_idx, input logic [22:0] exp_tag);
        logic [127:0] line;
        line = '0;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w <= waits; w++) begin
                chk("rd_req", mem_req, 1'b1);
                chk("rd_we", mem_we, 1'b0);
                chk("rd_addr", mem_addr, base + 32'(4 * k));
                chk("rd_nofill", fill_valid, 1'b0);
                if (w == waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd0 + 32'(k);
                    line[32*k +: 32] = rd0 + 32'(k);
                    if (k == wr_beat) begin
                        wr_req  = 1'b1;
                        wr_addr = wa;
                        wr_data = wd;
                    end
                end else begin
                    mem_ack = 1'b0;
                end
                tick();
                mem_ack = 1'b0;
                wr_req  = 1'b0;
            end
        end
        chk("fill_valid", fill_valid, 1'b1);
        chk("fill_index", fill_index, exp_idx);
        chk("fill_tag", fill_tag, exp_tag);
        chk("fill_data", fill_data, line);
        chk("fill_noreq", mem_req, 1'b0);
        tick();
        miss_req = 1'b0;
        chk("fill_pulse", fill_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1; miss_req = 1'b0; miss_addr = '0; wr_req = 1'b0;
        wr_addr = '0; wr_data = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_fill_valid", fill_valid, 1'b0);
        chk("rst_wr_busy", wr_busy, 1'b0);
        chk("rst_fill_data", fill_data, 128'h0);
        chk("rst_fill_index", fill_index, 5'h0);
        chk("rst_fill_tag", fill_tag, 23'h0);
        reset = 1'b0;
        tick();

        // Minimum-latency refill of line 0x120.
        miss_req = 1'b1; miss_addr = 32'h0000_0124;
        tick();
        run_beats(32'h120, 32'hA0, 0, -1, 32'h0, 32'h0, 5'h12, 23'h0);
        chk("t1_fill_data_const", fill_data, 128'h000000A3_000000A2_000000A1_000000A0);
        tick();
        chk("t1_no_respin", mem_req, 1'b0);

        // Same miss, three wait cycles per beat.
        miss_req = 1'b1; miss_addr = 32'h0000_0124;
        tick();
        run_beats(32'h120, 32'hB0, 3, -1, 32'h0, 32'h0, 5'h12, 23'h0);
        tick();
        chk("t2_no_respin", mem_req, 1'b0);

        // Store and miss in the same idle cycle: store goes first.
        wr_req = 1'b1; wr_addr = 32'h200; wr_data = 32'hDEADBEEF;
        miss_req = 1'b1; miss_addr = 32'h300;
        tick();
        wr_req = 1'b0;
        chk("t3_busy", wr_busy, 1'b1);
        chk("t3_wait", mem_req, 1'b0);
        tick();
        chk("t3_wr_req", mem_req, 1'b1);
        chk("t3_wr_we", mem_we, 1'b1);
        chk("t3_wr_addr", mem_addr, 32'h200);
        chk("t3_wr_data", mem_wdata, 32'hDEADBEEF);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t3_drained", wr_busy, 1'b0);
        chk("t3_gap", mem_req, 1'b0);
        tick();
        run_beats(32'h300, 32'hC0, 0, -1, 32'h0, 32'h0, 5'h10, 23'h1);

        // Back-to-back stores: second ignored while busy, retried after drain.
        tick();
        wr_req = 1'b1; wr_addr = 32'h400; wr_data = 32'h11111111;
        tick();
        chk("t4_busy1", wr_busy, 1'b1);
        wr_addr = 32'h404; wr_data = 32'h22222222;
        tick();
        wr_req = 1'b0;
        chk("t4_w1_addr", mem_addr, 32'h400);
        chk("t4_w1_data", mem_wdata, 32'h11111111);
        chk("t4_w1_we", mem_we, 1'b1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t4_drained", wr_busy, 1'b0);
        chk("t4_gap", mem_req, 1'b0);
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        chk("t4_busy2", wr_busy, 1'b1);
        tick();
        chk("t4_w2_req", mem_req, 1'b1);
        chk("t4_w2_addr", mem_addr, 32'h404);
        chk("t4_w2_data", mem_wdata, 32'h22222222);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t4_done", wr_busy, 1'b0);

        // Store during beat 2 of a refill: fill completes, then the write.
        miss_req = 1'b1; miss_addr = 32'h0000_0520;
        tick();
        run_beats(32'h520, 32'hE0, 0, 2, 32'h600, 32'hCAFEF00D, 5'h12, 23'h2);
        chk("t5_busy", wr_busy, 1'b1);
        chk("t5_idle", mem_req, 1'b0);
        tick();
        chk("t5_wr_req", mem_req, 1'b1);
        chk("t5_wr_we", mem_we, 1'b1);
        chk("t5_wr_addr", mem_addr, 32'h600);
        chk("t5_wr_data", mem_wdata, 32'hCAFEF00D);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t5_drained", wr_busy, 1'b0);

        // Reset after the second read ack: abort, clear, then restart at word 0.
        miss_req = 1'b1; miss_addr = 32'h0000_0124;
        tick();
        chk("t6_b0_addr", mem_addr, 32'h120);
        mem_ack = 1'b1; mem_rdata = 32'h5A;
        wr_req = 1'b1; wr_addr = 32'h700; wr_data = 32'h77;
        tick();
        wr_req = 1'b0;
        chk("t6_b1_addr", mem_addr, 32'h124);
        chk("t6_busy", wr_busy, 1'b1);
        mem_rdata = 32'h5B;
        tick();
        mem_ack = 1'b0;
        chk("t6_b2_addr", mem_addr, 32'h128);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_mem_req", mem_req, 1'b0);
        chk("t6_mem_we", mem_we, 1'b0);
        chk("t6_mem_addr", mem_addr, 32'h0);
        chk("t6_mem_wdata", mem_wdata, 32'h0);
        chk("t6_fill_valid", fill_valid, 1'b0);
        chk("t6_wr_busy", wr_busy, 1'b0);
        chk("t6_fill_data", fill_data, 128'h0);
        chk("t6_fill_index", fill_index, 5'h0);
        chk("t6_fill_tag", fill_tag, 23'h0);
        tick();
        run_beats(32'h120, 32'hD0, 0, -1, 32'h0, 32'h0, 5'h12, 23'h0);
        tick();
        chk("t6_no_respin", mem_req, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
